// File: rtl/minesweeper_pkg.sv
// rtl/minesweeper_pkg.sv - board constants, command/state/direction enums and neighbour helpers
package minesweeper_pkg;

    localparam int BOARD_W = 8;
    localparam int TILES   = 64;

    localparam logic signed [4:0] EDGE_MAX = 5'(BOARD_W - 1);

    typedef enum logic [1:0] {
        OP_STEP  = 2'd0,
        OP_FLAG  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_NOP   = 2'd3
    } cmdOp_e;

    typedef enum logic [2:0] {IDLE, POP, EVAL, SCAN, DONE, OVER} state_e;

    typedef enum logic [2:0] {
        DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
    } dir_e;

    // Returns {onBoard, index}; row/col are widened and signed so stepping off any edge is visible
    function automatic logic [6:0] neighbourOf(input logic [5:0] tile, input dir_e dir);
        logic signed [4:0] row;
        logic signed [4:0] col;
        logic              onBoard;
        row = $signed({2'b00, tile[5:3]});
        col = $signed({2'b00, tile[2:0]});
        case (dir)
            DIR_N:   row = row - 5'sd1;
            DIR_NE:  begin row = row - 5'sd1; col = col + 5'sd1; end
            DIR_E:   col = col + 5'sd1;
            DIR_SE:  begin row = row + 5'sd1; col = col + 5'sd1; end
            DIR_S:   row = row + 5'sd1;
            DIR_SW:  begin row = row + 5'sd1; col = col - 5'sd1; end
            DIR_W:   col = col - 5'sd1;
            DIR_NW:  begin row = row - 5'sd1; col = col - 5'sd1; end
            default: ;
        endcase
        onBoard = (row >= 5'sd0) && (row <= EDGE_MAX) && (col >= 5'sd0) && (col <= EDGE_MAX);
        return {onBoard, row[2:0], col[2:0]};
    endfunction

    function automatic logic [3:0] mineCount(input logic [TILES-1:0] mines, input logic [5:0] tile);
        logic [6:0] nb;
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int d = 0; d < 8; d++) begin
            nb = neighbourOf(tile, dir_e'(3'(d)));
            if (nb[6] && mines[nb[5:0]]) begin
                cnt = cnt + 4'd1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tile_fifo.sv
// rtl/tile_fifo.sv - pending-reveal tile queue: 6-bit entries, parameterised depth, async reset
module tile_fifo
    import minesweeper_pkg::*;
#(
    parameter int DEPTH = TILES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [5:0] pushData,
    input  logic       pop,
    output logic [5:0] popData,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [5:0]    mem [2**AW];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          doPop;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({push, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/reveal_ctrl.sv
// rtl/reveal_ctrl.sv - minesweeper reveal controller; define REVEAL_CTRL_FLOOD_EN for zero-count flood fill
module reveal_ctrl
    import minesweeper_pkg::*;
#(
    parameter int FLAG_LIMIT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [TILES-1:0] mine_map,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [5:0]       cmd_tile,
    output logic [TILES-1:0] step_map,
    output logic [TILES-1:0] flag_map,
    output logic             rev_valid,
    output logic [5:0]       rev_tile,
    output logic [3:0]       rev_count,
    output logic             busy,
    output logic             game_lost,
    output logic             game_won
);

`ifdef REVEAL_CTRL_FLOOD_EN
    localparam int QUEUE_DEPTH = TILES;
    localparam bit FLOOD_EN    = 1'b1;
`else
    localparam int QUEUE_DEPTH = 1;
    localparam bit FLOOD_EN    = 1'b0;
`endif

    state_e           state;
    dir_e             scanDir;
    cmdOp_e           op;
    logic [TILES-1:0] stepMap;
    logic [TILES-1:0] flagMap;
    logic [TILES-1:0] queuedMap;
    logic             revValid;
    logic [5:0]       revTile;
    logic [3:0]       revCount;
    logic             gameLost;
    logic             gameWon;
    logic [6:0]       flagCount;
    logic             cmdReady;

    logic [6:0] scanNb;
    logic       scanPush;
    logic       stepSafe;
    logic       fifoPush;
    logic [5:0] fifoData;
    logic       fifoEmpty;
    logic [5:0] headTile;

    assign op       = cmdOp_e'(cmd_op);
    assign cmdReady = (state == IDLE) || (state == OVER);

    assign stepSafe = (state == IDLE) && cmd_valid && (op == OP_STEP) &&
                      !stepMap[cmd_tile] && !flagMap[cmd_tile] && !mine_map[cmd_tile];

    // The queued bitmap keeps a tile from entering the queue twice within one reveal sequence
    assign scanNb   = neighbourOf(revTile, scanDir);
    assign scanPush = (state == SCAN) && scanNb[6] && !stepMap[scanNb[5:0]] &&
                      !flagMap[scanNb[5:0]] && !queuedMap[scanNb[5:0]];

    assign fifoPush = stepSafe || scanPush;
    assign fifoData = (state == SCAN) ? scanNb[5:0] : cmd_tile;

    tile_fifo #(.DEPTH(QUEUE_DEPTH)) queue (
        .clk      (clk),
        .reset    (reset),
        .push     (fifoPush),
        .pushData (fifoData),
        .pop      (state == POP),
        .popData  (headTile),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            scanDir   <= DIR_N;
            stepMap   <= '0;
            flagMap   <= '0;
            queuedMap <= '0;
            revValid  <= 1'b0;
            revTile   <= '0;
            revCount  <= '0;
            gameLost  <= 1'b0;
            gameWon   <= 1'b0;
            flagCount <= '0;
        end else begin
            revValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (op)
                            OP_STEP: begin
                                if (!stepMap[cmd_tile] && !flagMap[cmd_tile]) begin
                                    if (mine_map[cmd_tile]) begin
                                        stepMap[cmd_tile] <= 1'b1;
                                        gameLost          <= 1'b1;
                                        state             <= OVER;
                                    end else begin
                                        queuedMap[cmd_tile] <= 1'b1;
                                        state               <= POP;
                                    end
                                end
                            end
                            OP_FLAG: begin
                                if (!stepMap[cmd_tile]) begin
                                    if (flagMap[cmd_tile]) begin
                                        flagMap[cmd_tile] <= 1'b0;
                                        flagCount         <= flagCount - 7'd1;
                                    end else if (flagCount < 7'(FLAG_LIMIT)) begin
                                        flagMap[cmd_tile] <= 1'b1;
                                        flagCount         <= flagCount + 7'd1;
                                    end
                                end
                            end
                            OP_CLEAR: begin
                                stepMap   <= '0;
                                flagMap   <= '0;
                                flagCount <= '0;
                                gameLost  <= 1'b0;
                                gameWon   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                POP: begin
                    stepMap[headTile] <= 1'b1;
                    revTile           <= headTile;
                    revCount          <= mineCount(mine_map, headTile);
                    revValid          <= 1'b1;
                    state             <= EVAL;
                end
                EVAL: begin
                    if (FLOOD_EN && (revCount == 4'd0)) begin
                        scanDir <= DIR_N;
                        state   <= SCAN;
                    end else begin
                        state <= fifoEmpty ? DONE : POP;
                    end
                end
                SCAN: begin
                    if (scanPush) begin
                        queuedMap[scanNb[5:0]] <= 1'b1;
                    end
                    // A push on the last direction lands in the queue at this same edge
                    if (scanDir == DIR_NW) begin
                        state <= (!fifoEmpty || scanPush) ? POP : DONE;
                    end else begin
                        scanDir <= dir_e'(scanDir + 3'd1);
                    end
                end
                DONE: begin
                    queuedMap <= '0;
                    if (&(stepMap | mine_map)) begin
                        gameWon <= 1'b1;
                        state   <= OVER;
                    end else begin
                        state <= IDLE;
                    end
                end
                OVER: begin
                    if (cmd_valid && (op == OP_CLEAR)) begin
                        stepMap   <= '0;
                        flagMap   <= '0;
                        flagCount <= '0;
                        gameLost  <= 1'b0;
                        gameWon   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = cmdReady;
    assign busy      = (state == POP) || (state == EVAL) || (state == SCAN) || (state == DONE);
    assign step_map  = stepMap;
    assign flag_map  = flagMap;
    assign rev_valid = revValid;
    assign rev_tile  = revTile;
    assign rev_count = revCount;
    assign game_lost = gameLost;
    assign game_won  = gameWon;

endmodule
